// File: rtl/led_trail_pwm.sv
// Fading-trail LED driver: each strobed pattern bit loads full brightness, then
// decays one level per prescaler tick; levels drive PWM. Optional: LED_TRAIL_GAMMA_EN.
module led_trail_pwm #(
    parameter int unsigned LED_W = 10,
    parameter int unsigned LVL_W = 4,
    parameter int unsigned DEC_W = 20
) (
    input  logic             OSC_50m,
    input  logic             FPGA_RSTn,
    input  logic [LED_W-1:0] pat_i,
    input  logic             pat_vld_i,
    output logic [LED_W-1:0] USER_LED
);

    localparam int unsigned MAX_I = (1 << LVL_W) - 1;
    localparam logic [LVL_W-1:0] MAX = '1;

`ifdef LED_TRAIL_GAMMA_EN
    localparam int unsigned PWM_W = 2 * LVL_W;
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(MAX_I * MAX_I - 1);
`else
    localparam int unsigned PWM_W = LVL_W;
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(MAX_I - 1);
`endif

    logic                        rst_meta_q;
    logic                        rst_sync_q;
    logic                        rst_n_sync;

    logic [DEC_W-1:0]            dec_q;
    logic [DEC_W-1:0]            dec_d;
    logic                        dec_tick;

    logic [LED_W-1:0][LVL_W-1:0] lvl_q;
    logic [LED_W-1:0][LVL_W-1:0] lvl_d;

    logic [PWM_W-1:0]            pwm_q;
    logic [PWM_W-1:0]            pwm_d;
    logic [LED_W-1:0][PWM_W-1:0] duty;

    logic [LED_W-1:0]            led_q;
    logic [LED_W-1:0]            led_d;

    // Reset asserts asynchronously, releases two clocks after FPGA_RSTn rises.
    always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
        if (!FPGA_RSTn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n_sync = rst_sync_q;

    always_comb begin
        dec_d    = dec_q + DEC_W'(1);
        dec_tick = &dec_q;
    end

    // A load wins over a decrement for the same LED; clear pattern bits never clear a level.
    always_comb begin
        lvl_d = lvl_q;
        for (int unsigned i = 0; i < LED_W; i++) begin
            if (pat_vld_i && pat_i[i]) begin
                lvl_d[i] = MAX;
            end else if (dec_tick && (lvl_q[i] != '0)) begin
                lvl_d[i] = lvl_q[i] - LVL_W'(1);
            end
        end
    end

    always_comb begin
        pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_W'(1);
    end

    always_comb begin
        duty  = '0;
        led_d = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
`ifdef LED_TRAIL_GAMMA_EN
            duty[i] = PWM_W'(lvl_q[i]) * PWM_W'(lvl_q[i]);
`else
            duty[i] = lvl_q[i];
`endif
            led_d[i] = (duty[i] > pwm_q);
        end
    end

    always_ff @(posedge OSC_50m or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            dec_q <= '0;
            lvl_q <= '0;
            pwm_q <= '0;
            led_q <= '0;
        end else begin
            dec_q <= dec_d;
            lvl_q <= lvl_d;
            pwm_q <= pwm_d;
            led_q <= led_d;
        end
    end

    assign USER_LED = led_q;

endmodule
